// File: rtl/ram_port_arbiter.sv
// Arbiter and CLEAR sequencer for a shared word-select RAM bank (1 write, 2 read ports).
// Optional macro ARB_BYPASS_EN: same-cycle same-address read returns the write data.
module ram_port_arbiter #(
    parameter int DATA_W = 2,
    parameter int ADDR_W = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear_req,
    output logic                    busy,
    output logic                    clear_done,
    input  logic                    req_a,
    input  logic                    we_a,
    input  logic [ADDR_W-1:0]       addr_a,
    input  logic [DATA_W-1:0]       wdata_a,
    output logic                    gnt_a,
    output logic                    rvalid_a,
    output logic [DATA_W-1:0]       rdata_a,
    input  logic                    req_b,
    input  logic                    we_b,
    input  logic [ADDR_W-1:0]       addr_b,
    input  logic [DATA_W-1:0]       wdata_b,
    output logic                    gnt_b,
    output logic                    rvalid_b,
    output logic [DATA_W-1:0]       rdata_b,
    output logic [DATA_W-1:0]       ram_write_data,
    output logic [(2**ADDR_W)-1:0]  ram_write_select,
    output logic [(2**ADDR_W)-1:0]  ram_read_select_1,
    output logic [(2**ADDR_W)-1:0]  ram_read_select_2,
    input  logic [DATA_W-1:0]       ram_read_data_1,
    input  logic [DATA_W-1:0]       ram_read_data_2
);

    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;            // 0: A has write priority, 1: B
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0]   rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic                clear_done_q, clear_done_d;
    logic                rd_a, rd_b, win_a, win_b, last_word;

    function automatic logic [DEPTH-1:0] onehot(input logic [ADDR_W-1:0] a);
        logic [DEPTH-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rr_q         <= 1'b0;
            cnt_q        <= '0;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
            rdata_a_q    <= '0;
            rdata_b_q    <= '0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            cnt_q        <= cnt_d;
            rvalid_a_q   <= rvalid_a_d;
            rvalid_b_q   <= rvalid_b_d;
            rdata_a_q    <= rdata_a_d;
            rdata_b_q    <= rdata_b_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign last_word = (cnt_q == ADDR_W'(DEPTH-1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rr_d         = rr_q;
        clear_done_d = 1'b0;
        rvalid_a_d   = rd_a;
        rvalid_b_d   = rd_b;
        rdata_a_d    = rdata_a_q;
        rdata_b_d    = rdata_b_q;
        if (rd_a) rdata_a_d = ram_read_data_1;
        if (rd_b) rdata_b_d = ram_read_data_2;
`ifdef ARB_BYPASS_EN
        if (rd_a && |(ram_write_select & ram_read_select_1)) rdata_a_d = ram_write_data;
        if (rd_b && |(ram_write_select & ram_read_select_2)) rdata_b_d = ram_write_data;
`endif
        if (win_a) rr_d = 1'b1;
        if (win_b) rr_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (last_word) begin
                    state_d      = ST_IDLE;
                    clear_done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_a              = 1'b0;
        rd_b              = 1'b0;
        win_a             = 1'b0;
        win_b             = 1'b0;
        ram_write_select  = '0;
        ram_write_data    = '0;
        ram_read_select_1 = '0;
        ram_read_select_2 = '0;
        busy              = (state_q == ST_CLEAR);
        if (state_q == ST_IDLE) begin
            rd_a  = req_a && !we_a;
            rd_b  = req_b && !we_b;
            win_a = req_a && we_a && (!(req_b && we_b) || !rr_q);
            win_b = req_b && we_b && (!(req_a && we_a) || rr_q);
            if (rd_a) ram_read_select_1 = onehot(addr_a);
            if (rd_b) ram_read_select_2 = onehot(addr_b);
            if (win_a) begin
                ram_write_select = onehot(addr_a);
                ram_write_data   = wdata_a;
            end else if (win_b) begin
                ram_write_select = onehot(addr_b);
                ram_write_data   = wdata_b;
            end
        end else begin
            ram_write_select = onehot(cnt_q);
        end
        gnt_a = rd_a || win_a;
        gnt_b = rd_b || win_b;
    end

    assign rvalid_a   = rvalid_a_q;
    assign rvalid_b   = rvalid_b_q;
    assign rdata_a    = rdata_a_q;
    assign rdata_b    = rdata_b_q;
    assign clear_done = clear_done_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural non-resettable RAM bank.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clear_req = 1'b0;
    logic       busy, clear_done;
    logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
    logic [0:0] addr_a = '0, addr_b = '0;
    logic [1:0] wdata_a = '0, wdata_b = '0;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [1:0] rdata_a, rdata_b;
    logic [1:0] ram_write_data, ram_write_select, ram_read_select_1, ram_read_select_2;
    logic [1:0] ram_read_data_1, ram_read_data_2;

    int n_cmp = 0;
    int n_err = 0;

    logic       bank_init = 1'b1;
    logic [1:0] mem [0:1];

    always #5 clk = ~clk;

    ram_port_arbiter #(.DATA_W(2), .ADDR_W(1)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy), .clear_done(clear_done),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
        .ram_write_data(ram_write_data), .ram_write_select(ram_write_select),
        .ram_read_select_1(ram_read_select_1), .ram_read_select_2(ram_read_select_2),
        .ram_read_data_1(ram_read_data_1), .ram_read_data_2(ram_read_data_2)
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bank_init) mem[i] <= 2'b00;
            else if (ram_write_select[i]) mem[i] <= ram_write_data;
        end
    end

    always_comb begin
        ram_read_data_1 = '0;
        ram_read_data_2 = '0;
        for (int i = 0; i < 2; i++) begin
            if (ram_read_select_1[i]) ram_read_data_1 = ram_read_data_1 | mem[i];
            if (ram_read_select_2[i]) ram_read_data_2 = ram_read_data_2 | mem[i];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        req_a = 1'b0; we_a = 1'b0; req_b = 1'b0; we_b = 1'b0; clear_req = 1'b0;
    endtask

    task automatic drive_a(input logic we, input logic ad, input logic [1:0] wd);
        req_a = 1'b1; we_a = we; addr_a = ad; wdata_a = wd;
    endtask

    task automatic drive_b(input logic we, input logic ad, input logic [1:0] wd);
        req_b = 1'b1; we_b = we; addr_b = ad; wdata_b = wd;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(); tick();
        bank_init = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL reset_clear_done: got %b want 0", clear_done); end
        n_cmp++; if ({rvalid_a, rvalid_b} !== 2'b00) begin n_err++; $display("FAIL reset_rvalid: got %b want 00", {rvalid_a, rvalid_b}); end
        n_cmp++; if ({rdata_a, rdata_b} !== 4'b0000) begin n_err++; $display("FAIL reset_rdata: got %b want 0000", {rdata_a, rdata_b}); end
        n_cmp++; if (ram_write_select !== 2'b00) begin n_err++; $display("FAIL reset_wsel: got %b want 00", ram_write_select); end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_write_read;
        drive_a(1'b1, 1'b1, 2'b10);
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b10) begin n_err++; $display("FAIL wr_gnt: got %b want 10", {gnt_a, gnt_b}); end
        n_cmp++; if (ram_write_select !== 2'b10) begin n_err++; $display("FAIL wr_wsel: got %b want 10", ram_write_select); end
        n_cmp++; if (ram_write_data !== 2'b10) begin n_err++; $display("FAIL wr_wdata: got %b want 10", ram_write_data); end
        tick();
        drive_a(1'b0, 1'b1, 2'b00);
        #1;
        n_cmp++; if (rvalid_a !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %b want 0", rvalid_a); end
        n_cmp++; if (gnt_a !== 1'b1) begin n_err++; $display("FAIL rd_gnt: got %b want 1", gnt_a); end
        n_cmp++; if (ram_read_select_1 !== 2'b10) begin n_err++; $display("FAIL rd_rsel1: got %b want 10", ram_read_select_1); end
        n_cmp++; if (ram_write_select !== 2'b00 || ram_write_data !== 2'b00) begin n_err++; $display("FAIL rd_no_write: got %b/%b want 00/00", ram_write_select, ram_write_data); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (rvalid_a !== 1'b1) begin n_err++; $display("FAIL rd_rvalid: got %b want 1", rvalid_a); end
        n_cmp++; if (rdata_a !== 2'b10) begin n_err++; $display("FAIL rd_rdata: got %b want 10", rdata_a); end
        tick();
        n_cmp++; if (rvalid_a !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_pulse: got %b want 0", rvalid_a); end
    endtask

    task automatic test_write_conflict;
        do_reset();
        drive_a(1'b1, 1'b0, 2'b01);
        drive_b(1'b1, 1'b0, 2'b11);
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b10) begin n_err++; $display("FAIL conf_c0_gnt: got %b want 10", {gnt_a, gnt_b}); end
        n_cmp++; if (ram_write_data !== 2'b01) begin n_err++; $display("FAIL conf_c0_wdata: got %b want 01", ram_write_data); end
        tick();
        req_a = 1'b0;
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b01) begin n_err++; $display("FAIL conf_c1_gnt: got %b want 01", {gnt_a, gnt_b}); end
        n_cmp++; if (ram_write_data !== 2'b11 || ram_write_select !== 2'b01) begin n_err++; $display("FAIL conf_c1_write: got %b/%b want 11/01", ram_write_data, ram_write_select); end
        tick();
        idle_inputs();
        drive_a(1'b0, 1'b0, 2'b00);
        tick();
        idle_inputs();
        n_cmp++; if (rdata_a !== 2'b11) begin n_err++; $display("FAIL conf_readback: got %b want 11", rdata_a); end
        // B won last, so A now holds priority on the next collision
        drive_a(1'b1, 1'b1, 2'b00);
        drive_b(1'b1, 1'b1, 2'b00);
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b10) begin n_err++; $display("FAIL conf_rr: got %b want 10", {gnt_a, gnt_b}); end
        tick();
        req_a = 1'b0;
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_mixed;
        drive_a(1'b0, 1'b0, 2'b00);
        drive_b(1'b1, 1'b1, 2'b01);
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b11) begin n_err++; $display("FAIL mix_gnt: got %b want 11", {gnt_a, gnt_b}); end
        n_cmp++; if (ram_read_select_1 !== 2'b01 || ram_read_select_2 !== 2'b00) begin n_err++; $display("FAIL mix_rsel: got %b/%b want 01/00", ram_read_select_1, ram_read_select_2); end
        n_cmp++; if (ram_write_select !== 2'b10) begin n_err++; $display("FAIL mix_wsel: got %b want 10", ram_write_select); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if ({rvalid_a, rvalid_b} !== 2'b10) begin n_err++; $display("FAIL mix_rvalid: got %b want 10", {rvalid_a, rvalid_b}); end
        n_cmp++; if (rdata_a !== 2'b11) begin n_err++; $display("FAIL mix_rdata: got %b want 11", rdata_a); end
        tick();
    endtask

    task automatic test_clear;
        drive_a(1'b1, 1'b0, 2'b11);
        tick();
        drive_a(1'b1, 1'b1, 2'b11);
        tick();
        idle_inputs();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        drive_a(1'b1, 1'b0, 2'b11);
        drive_b(1'b0, 1'b1, 2'b00);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clr_busy0: got %b want 1", busy); end
        n_cmp++; if (ram_write_select !== 2'b01 || ram_write_data !== 2'b00) begin n_err++; $display("FAIL clr_w0: got %b/%b want 01/00", ram_write_select, ram_write_data); end
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b00) begin n_err++; $display("FAIL clr_gnt: got %b want 00", {gnt_a, gnt_b}); end
        n_cmp++; if (ram_read_select_2 !== 2'b00) begin n_err++; $display("FAIL clr_rsel2: got %b want 00", ram_read_select_2); end
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b1 || ram_write_select !== 2'b10) begin n_err++; $display("FAIL clr_w1: got busy %b wsel %b want 1/10", busy, ram_write_select); end
        n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_early: got %b want 0", clear_done); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy !== 1'b0 || clear_done !== 1'b1) begin n_err++; $display("FAIL clr_done: got busy %b done %b want 0/1", busy, clear_done); end
        drive_a(1'b0, 1'b0, 2'b00);
        drive_b(1'b0, 1'b1, 2'b00);
        tick();
        idle_inputs();
        n_cmp++; if (clear_done !== 1'b0) begin n_err++; $display("FAIL clr_done_pulse: got %b want 0", clear_done); end
        n_cmp++; if ({rvalid_a, rvalid_b, rdata_a, rdata_b} !== 6'b110000) begin n_err++; $display("FAIL clr_readback: got %b want 110000", {rvalid_a, rvalid_b, rdata_a, rdata_b}); end
        tick();
    endtask

    task automatic test_retrigger;
        clear_req = 1'b1;
        tick();
        tick();
        tick();
        n_cmp++; if (clear_done !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL retrig_done: got done %b busy %b want 1/0", clear_done, busy); end
        tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL retrig_busy: got %b want 1", busy); end
        clear_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_clear;
        drive_a(1'b1, 1'b0, 2'b11);
        tick();
        drive_a(1'b1, 1'b1, 2'b11);
        tick();
        idle_inputs();
        drive_a(1'b0, 1'b0, 2'b00);
        clear_req = 1'b1;
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (busy !== 1'b1 || rvalid_a !== 1'b1) begin n_err++; $display("FAIL mid_pre: got busy %b rvalid %b want 1/1", busy, rvalid_a); end
        reset = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0 || rvalid_a !== 1'b0) begin n_err++; $display("FAIL mid_reset: got busy %b rvalid %b want 0/0", busy, rvalid_a); end
        n_cmp++; if (ram_write_select !== 2'b00) begin n_err++; $display("FAIL mid_wsel: got %b want 00", ram_write_select); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (clear_done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_no_done: cycle %0d got done %b busy %b want 0/0", i, clear_done, busy); end
        end
        drive_b(1'b0, 1'b1, 2'b00);
        tick();
        idle_inputs();
        n_cmp++; if (rdata_b !== 2'b11) begin n_err++; $display("FAIL mid_word1: got %b want 11", rdata_b); end
        tick();
    endtask

    task automatic test_same_addr;
        logic [1:0] exp;
`ifdef ARB_BYPASS_EN
        exp = 2'b10;
`else
        exp = 2'b01;
`endif
        drive_b(1'b1, 1'b0, 2'b01);
        tick();
        idle_inputs();
        drive_a(1'b0, 1'b0, 2'b00);
        drive_b(1'b1, 1'b0, 2'b10);
        #1;
        n_cmp++; if ({gnt_a, gnt_b} !== 2'b11) begin n_err++; $display("FAIL same_gnt: got %b want 11", {gnt_a, gnt_b}); end
        tick();
        idle_inputs();
        drive_a(1'b0, 1'b0, 2'b00);
        #1;
        n_cmp++; if (rdata_a !== exp) begin n_err++; $display("FAIL same_rdata: got %b want %b", rdata_a, exp); end
        tick();
        idle_inputs();
        n_cmp++; if (rdata_a !== 2'b10) begin n_err++; $display("FAIL same_after: got %b want 10", rdata_a); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_write_conflict();
        test_mixed();
        test_clear();
        test_retrigger();
        test_reset_mid_clear();
        test_same_addr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one word-organised register RAM bank between two requesters (A, B). The bank is built from the team's word-select RAM cells, with one write port and two read ports. Each requester owns one read port; the single write port is arbitrated round-robin. A CLEAR sequencer zeroes every word on demand. The block sits between the datapath requesters and the RAM bank and drives all of the bank's select lines.

Parameters:
DATA_W, 2, word width in bits
ADDR_W, 1, address width; DEPTH = 2**ADDR_W words (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
clear_req  in  1  start CLEAR sweep (sampled in IDLE)
busy  out  1  high while in CLEAR
clear_done  out  1  one-cycle pulse after the sweep completes
req_a  in  1  requester A access request; held until gnt_a
we_a  in  1  A: 1 = write, 0 = read
addr_a  in  ADDR_W  A word address
wdata_a  in  DATA_W  A write data
gnt_a  out  1  A request accepted this cycle
rvalid_a  out  1  A read data valid
rdata_a  out  DATA_W  A read data (registered)
req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b  (same as A, for requester B)
ram_write_data  out  DATA_W  write data to the bank
ram_write_select  out  DEPTH  one-hot write-enable per word
ram_read_select_1  out  DEPTH  one-hot read select, port 1 (serves A)
ram_read_select_2  out  DEPTH  one-hot read select, port 2 (serves B)
ram_read_data_1  in  DATA_W  bank port 1 data (combinational)
ram_read_data_2  in  DATA_W  bank port 2 data (combinational)

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high.
- Reset values: state=IDLE, rr pointer=A, sweep counter=0, rdata_a/b=0, rvalid_a/b=0, clear_done=0, busy=0.
- All selects and grants are combinational from state, requests and rr; all other state is registered.
- Reads in IDLE:
  - Always granted in the same cycle (gnt=1); never conflict, since each requester has a dedicated port.
  - ram_read_select_1 = onehot(addr_a) when A's read is granted, else 0. Same for B on port 2.
  - rdata is captured at the clock edge; rvalid=1 for exactly one cycle after the grant cycle (latency 1).
- Writes in IDLE, one per cycle:
  - Single writer: granted immediately.
  - Both writing: the requester pointed to by rr wins. The loser sees gnt=0, must hold its request, and is granted next cycle (bounded wait 1 cycle).
  - After any write grant, rr points to the other requester.
  - ram_write_select = onehot(winner addr); ram_write_data = winner wdata. The bank updates at the next edge.
  - No write granted: ram_write_select=0, ram_write_data=0.
- Mixed traffic: A reading while B writes (or vice versa) are both granted in the same cycle.
- Same-address read/write in one cycle: the read returns the pre-write value (see macro).
- CLEAR sweep:
  - clear_req=1 in IDLE: that cycle arbitrates normally; next state is CLEAR with counter=0.
  - In CLEAR: ram_write_select=onehot(counter), ram_write_data=0; all gnt=0; read selects=0; busy=1; counter increments each cycle.
  - counter==DEPTH-1: next state IDLE, and clear_done=1 for the first IDLE cycle. The sweep lasts exactly DEPTH cycles.
  - clear_req during CLEAR is ignored. clear_req held high re-triggers the sweep after clear_done.
- Reset mid-CLEAR: immediate return to IDLE; no clear_done pulse; words already swept remain 0.
- rvalid is never asserted for a write or for an ungranted request.

Optional Feature:
ARB_BYPASS_EN
- Defined: if a granted read and a granted write target the same address in the same cycle, the registered rdata takes the write data instead of the RAM output.
- Undefined: rdata always comes from ram_read_data (old value).

Test Plan:
1. Reset, then A writes 2'b10 to addr 1 -> write_select=2'b10, gnt_a=1. Next cycle A reads addr 1 -> following cycle rvalid_a=1, rdata_a=2'b10.
2. After reset, A writes 2'b01 and B writes 2'b11, both to addr 0, held high -> cycle 0: gnt_a=1, gnt_b=0; cycle 1: gnt_b=1. Subsequent read of addr 0 returns 2'b11.
3. A reads addr 0 while B writes 2'b01 to addr 1 -> gnt_a=gnt_b=1 in the same cycle; read_select_1=2'b01, write_select=2'b10; rvalid_a next cycle.
4. Write 2'b11 to both words, pulse clear_req -> busy=1 for 2 cycles, write_select 2'b01 then 2'b10 with data 0, all gnt=0, then clear_done pulse. Reads of both words return 2'b00.
5. Assert reset in the first CLEAR cycle -> busy=0 and rvalid=0 immediately, clear_done never pulses; word 1 keeps its old value if the bank itself is not reset.
6. A reads addr 0 while B writes 2'b10 to addr 0 (word held 2'b01) -> rdata_a=2'b01 without ARB_BYPASS_EN, 2'b10 with it.
